// File: rtl/pipelined_memory_fifo.sv
// Single-clock FIFO: writes become readable through a 2-cycle commit pipeline; reads come out
// after a fixed READ_LATENCY (MLAB 2, M20K 3, plus EXTRA_OUTPUT_STAGES) on registered outputs.
module pipelined_memory_fifo #(
    parameter int    WIDTH               = 20,
    parameter int    DEPTH_LOG2          = 5,
    parameter string MEMORY_TYPE         = "MLAB",
    parameter int    EXTRA_OUTPUT_STAGES = 0,
    parameter int    ALMOST_FULL         = (1 << DEPTH_LOG2) - 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  writeEnable,
    input  logic [WIDTH-1:0]      dataIn,
    input  logic                  readRequest,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  dataOutValid,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  overflowError,
    output logic                  underflowError,
    output logic                  eccError
);
    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam bit IS_M20K      = (MEMORY_TYPE == "M20K");
    localparam int READ_LATENCY = (IS_M20K ? 3 : 2) + EXTRA_OUTPUT_STAGES;
    localparam int NSTAGE       = READ_LATENCY - 1;

    localparam logic [DEPTH_LOG2:0]   DEPTH_W = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AF_W    = (DEPTH_LOG2 + 1)'(ALMOST_FULL);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    function automatic logic parity_f(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    // Each word is stored with a parity bit that models the M20K ECC status on read-out.
    logic [WIDTH:0]          mem_q [DEPTH];
    logic [WIDTH:0]          mem_wdata_s;
    logic [WIDTH:0]          rd_word_s;

    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_addr_q, rd_addr_d;
    logic [DEPTH_LOG2:0]     usedw_q, usedw_d;
    logic [DEPTH_LOG2:0]     commit_q, commit_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    rd_v_q, rd_v_d;
    logic [NSTAGE-1:0]       pipe_v_q, pipe_v_d;
    logic [NSTAGE-1:0]       pipe_ecc_q, pipe_ecc_d;
    logic [WIDTH-1:0]        pipe_data_q [NSTAGE];
    logic [WIDTH-1:0]        pipe_data_d [NSTAGE];
    logic                    of_q, of_d;
    logic                    uf_q, uf_d;
    logic                    ecc_q, ecc_d;
    logic                    wr_acc_s, rd_acc_s;

    assign full       = (usedw_q == DEPTH_W);
    assign almostFull = (usedw_q >= AF_W);
    assign empty      = (commit_q == CNT_ZERO);

    // Next-state logic for pointers, occupancy, commit pipeline, read pipeline and sticky flags.
    always_comb begin
        wr_acc_s    = writeEnable & ~full;
        rd_acc_s    = readRequest & ~empty;
        mem_wdata_s = {parity_f(dataIn), dataIn};
        rd_word_s   = mem_q[rd_addr_q];

        wr_ptr_d  = wr_acc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = rd_acc_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        rd_addr_d = rd_acc_s ? rd_ptr_q : rd_addr_q;
        rd_v_d    = rd_acc_s;
        wr_pend_d = wr_acc_s;

        case ({wr_acc_s, rd_acc_s})
            2'b10:   usedw_d = usedw_q + CNT_ONE;
            2'b01:   usedw_d = usedw_q - CNT_ONE;
            default: usedw_d = usedw_q;
        endcase

        // A write only counts as readable one edge after its acceptance edge.
        case ({wr_pend_q, rd_acc_s})
            2'b10:   commit_d = commit_q + CNT_ONE;
            2'b01:   commit_d = commit_q - CNT_ONE;
            default: commit_d = commit_q;
        endcase

        pipe_v_d    = pipe_v_q;
        pipe_ecc_d  = pipe_ecc_q;
        pipe_data_d = pipe_data_q;
        pipe_v_d[0]    = rd_v_q;
        pipe_ecc_d[0]  = IS_M20K & rd_v_q & (parity_f(rd_word_s[WIDTH-1:0]) != rd_word_s[WIDTH]);
        // Idle read slots carry zero data, so the output is zero whenever it is not valid.
        pipe_data_d[0] = rd_v_q ? rd_word_s[WIDTH-1:0] : {WIDTH{1'b0}};
        for (int i = 1; i < NSTAGE; i++) begin
            pipe_v_d[i]    = pipe_v_q[i-1];
            pipe_ecc_d[i]  = pipe_ecc_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
        end

        of_d  = of_q | (writeEnable & full);
        uf_d  = uf_q | (readRequest & empty);
        ecc_d = ecc_q | (pipe_v_q[NSTAGE-1] & pipe_ecc_q[NSTAGE-1]);
    end

    // Control and read-pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
            rd_addr_q  <= {DEPTH_LOG2{1'b0}};
            usedw_q    <= CNT_ZERO;
            commit_q   <= CNT_ZERO;
            wr_pend_q  <= 1'b0;
            rd_v_q     <= 1'b0;
            pipe_v_q   <= {NSTAGE{1'b0}};
            pipe_ecc_q <= {NSTAGE{1'b0}};
            for (int i = 0; i < NSTAGE; i++) begin
                pipe_data_q[i] <= {WIDTH{1'b0}};
            end
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
            ecc_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_addr_q   <= rd_addr_d;
            usedw_q     <= usedw_d;
            commit_q    <= commit_d;
            wr_pend_q   <= wr_pend_d;
            rd_v_q      <= rd_v_d;
            pipe_v_q    <= pipe_v_d;
            pipe_ecc_q  <= pipe_ecc_d;
            pipe_data_q <= pipe_data_d;
            of_q        <= of_d;
            uf_q        <= uf_d;
            ecc_q       <= ecc_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= mem_wdata_s;
        end
    end

    assign dataOut        = pipe_data_q[NSTAGE-1];
    assign dataOutValid   = pipe_v_q[NSTAGE-1];
    assign usedw          = usedw_q;
    assign overflowError  = of_q;
    assign underflowError = uf_q;
    assign eccError       = ecc_q;

endmodule

// File: tb/tb_pipelined_memory_fifo.sv
// Directed bench: an MLAB instance with default parameters and an M20K instance with one
// extra output stage, checked against hand-computed vectors and a bench-side data queue.
module tb_pipelined_memory_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m_we, m_rr, m_valid, m_full, m_empty, m_af, m_of, m_uf, m_ecc;
    logic [19:0] m_din, m_dout;
    logic [5:0]  m_usedw;
    logic        s_we, s_rr, s_valid, s_full, s_empty, s_af, s_of, s_uf, s_ecc;
    logic [19:0] s_din, s_dout;
    logic [5:0]  s_usedw;

    pipelined_memory_fifo u_mlab (
        .clk(clk), .rst_n(rst_n), .writeEnable(m_we), .dataIn(m_din), .readRequest(m_rr),
        .dataOut(m_dout), .dataOutValid(m_valid), .usedw(m_usedw), .full(m_full),
        .empty(m_empty), .almostFull(m_af), .overflowError(m_of),
        .underflowError(m_uf), .eccError(m_ecc)
    );

    pipelined_memory_fifo #(.MEMORY_TYPE("M20K"), .EXTRA_OUTPUT_STAGES(1)) u_m20k (
        .clk(clk), .rst_n(rst_n), .writeEnable(s_we), .dataIn(s_din), .readRequest(s_rr),
        .dataOut(s_dout), .dataOutValid(s_valid), .usedw(s_usedw), .full(s_full),
        .empty(s_empty), .almostFull(s_af), .overflowError(s_of),
        .underflowError(s_uf), .eccError(s_ecc)
    );

    typedef struct {
        logic        we;
        logic [19:0] din;
        logic        rr;
        logic        valid;
        logic [19:0] dout;
        logic [5:0]  usedw;
        logic        empty;
        logic        uf;
    } vec_t;

    vec_t        vecs [18];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_valid = 0;
    int          first_v = 0;
    int          last_v = 0;
    bit          sb_en = 1'b0;
    logic [19:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [19:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (m_valid) begin
            if (n_valid == 0) first_v = cyc;
            last_v = cyc;
            n_valid++;
        end
        if (sb_en && m_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", m_dout, e);
            end
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_m_valid", m_valid, 0);   chk("rst_m_dout", m_dout, 0);
        chk("rst_m_usedw", m_usedw, 0);   chk("rst_m_empty", m_empty, 1);
        chk("rst_m_full", m_full, 0);     chk("rst_m_af", m_af, 0);
        chk("rst_m_flags", {m_of, m_uf, m_ecc}, 0);
        chk("rst_s_valid", s_valid, 0);   chk("rst_s_dout", s_dout, 0);
        chk("rst_s_usedw", s_usedw, 0);   chk("rst_s_empty", s_empty, 1);
        chk("rst_s_flags", {s_of, s_uf, s_ecc}, 0);
    endtask

    initial begin
        int errs;
        logic [19:0] d;
        //                we    din         rr    valid dout        usedw empty uf
        vecs[0]  = '{1'b1, 20'h00001, 1'b0, 1'b0, 20'h00000, 6'd1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 6'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 20'h00000, 1'b0, 1'b1, 20'h00001, 6'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 20'hABCDE, 1'b1, 1'b0, 20'h00000, 6'd1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 6'd1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 20'h12345, 1'b1, 1'b0, 20'h00000, 6'd1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 20'h00000, 1'b0, 1'b1, 20'hABCDE, 6'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 20'h00000, 1'b0, 1'b1, 20'h12345, 6'd0, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 20'h00777, 1'b0, 1'b0, 20'h00000, 6'd1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000, 6'd1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b1};
        vecs[16] = '{1'b0, 20'h00000, 1'b0, 1'b1, 20'h00777, 6'd0, 1'b1, 1'b1};
        vecs[17] = '{1'b0, 20'h00000, 1'b0, 1'b0, 20'h00000, 6'd0, 1'b1, 1'b1};

        rst_n = 1'b0;
        m_we = 1'b0; m_rr = 1'b0; m_din = 20'h0;
        s_we = 1'b0; s_rr = 1'b0; s_din = 20'h0;
        repeat (3) tick();
        chk_reset_state();

        // Table: first vector lands on the first edge with rst_n high.
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            m_we = vecs[i].we; m_din = vecs[i].din; m_rr = vecs[i].rr;
            tick();
            chk($sformatf("v%0d_valid", i), m_valid, vecs[i].valid);
            chk($sformatf("v%0d_dout", i), m_dout, vecs[i].dout);
            chk($sformatf("v%0d_usedw", i), m_usedw, vecs[i].usedw);
            chk($sformatf("v%0d_empty", i), m_empty, vecs[i].empty);
            chk($sformatf("v%0d_uf", i), m_uf, vecs[i].uf);
        end
        m_we = 1'b0; m_rr = 1'b0;

        // Fill to 32 starting at pointer 4, so storage wraps.
        sb_en = 1'b1;
        chk("fill_of_before", m_of, 0);
        for (int i = 0; i < 32; i++) begin
            m_we = 1'b1; m_din = 20'h10000 + 20'(i * 7);
            exp_q.push_back(m_din);
            tick();
            if (i == 26) chk("af_at_27", m_af, 0);
            if (i == 27) chk("af_at_28", m_af, 1);
            if (i == 30) chk("full_at_31", m_full, 0);
        end
        chk("fill_full", m_full, 1);
        chk("fill_usedw", m_usedw, 32);
        chk("fill_of_still0", m_of, 0);
        m_din = 20'hFFFFF;
        tick();
        chk("ovf_flag", m_of, 1);
        chk("ovf_usedw", m_usedw, 32);
        m_we = 1'b0;
        repeat (2) tick();

        n_valid = 0;
        m_rr = 1'b1;
        repeat (32) tick();
        m_rr = 1'b0;
        repeat (3) tick();
        chk("drain_count", n_valid, 32);
        chk("drain_no_bubbles", last_v - first_v, 31);
        chk("drain_usedw", m_usedw, 0);
        chk("drain_empty", m_empty, 1);
        chk("drain_dout_idle", m_dout, 0);

        // Steady simultaneous read/write at occupancy 10.
        for (int i = 0; i < 10; i++) begin
            m_we = 1'b1; m_din = 20'h30000 + 20'(i);
            exp_q.push_back(m_din);
            tick();
        end
        m_we = 1'b0;
        repeat (2) tick();
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            m_we = 1'b1; m_rr = 1'b1; m_din = 20'h40000 + 20'(i * 3);
            exp_q.push_back(m_din);
            tick();
            if (m_usedw !== 6'd10 || m_af !== 1'b0) errs++;
        end
        chk("rw_steady_cycles_bad", errs, 0);
        m_rr = 1'b0;
        for (int i = 0; i < 22; i++) begin
            m_we = 1'b1; m_din = 20'h50000 + 20'(i);
            exp_q.push_back(m_din);
            tick();
        end
        m_we = 1'b0;
        repeat (2) tick();
        chk("refill_full", m_full, 1);
        m_we = 1'b1; m_rr = 1'b1; m_din = 20'hBAD00;
        tick();
        chk("full_rw_usedw", m_usedw, 31);
        chk("full_rw_full", m_full, 0);
        m_we = 1'b0;
        repeat (31) tick();
        m_rr = 1'b0;
        repeat (4) tick();
        chk("final_queue_left", exp_q.size(), 0);
        chk("final_usedw", m_usedw, 0);
        chk("mlab_ecc", m_ecc, 0);

        // M20K, latency 4: 16-read burst.
        for (int i = 0; i < 16; i++) begin
            s_we = 1'b1; s_din = 20'h20000 + 20'(i);
            tick();
        end
        s_we = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 25; k++) begin
            s_rr = (k < 16);
            tick();
            d = (k >= 3 && k <= 18) ? 20'h20000 + 20'(k - 3) : 20'h0;
            chk($sformatf("m20k_burst_k%0d", k), {s_valid, s_dout}, {(k >= 3 && k <= 18), d});
        end
        s_rr = 1'b0;
        chk("m20k_usedw", s_usedw, 0);
        chk("m20k_ecc", s_ecc, 0);
        chk("m20k_uf", s_uf, 0);

        // Reset with two M20K reads in flight.
        for (int i = 0; i < 2; i++) begin
            s_we = 1'b1; s_din = 20'h60000 + 20'(i);
            tick();
        end
        s_we = 1'b0;
        repeat (2) tick();
        s_rr = 1'b1;
        repeat (2) tick();
        s_rr = 1'b0;
        rst_n = 1'b0;
        tick();
        chk_reset_state();
        tick();
        rst_n = 1'b1;
        m_we = 1'b1; m_din = 20'h0ACE1;
        exp_q.push_back(m_din);
        tick();
        chk("first_edge_write", m_usedw, 1);
        m_we = 1'b0;
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (s_valid !== 1'b0) errs++;
        end
        chk("flushed_reads_valid_cycles", errs, 0);
        m_rr = 1'b1;
        tick();
        m_rr = 1'b0;
        repeat (3) tick();
        chk("post_reset_queue_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
